// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with step enable, runtime seed load and hardware period measurement.
// Optional zero-state recovery is enabled by defining LFSR_ZERO_RECOVER_EN.
module lfsr_gen #(
  parameter int unsigned      WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = 5'b01001,
  parameter logic [WIDTH-1:0] SEED  = 5'b11111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic             out,
  output logic [WIDTH-1:0] state,
  output logic             period_done,
  output logic [WIDTH-1:0] period,
  output logic             stuck
);

`ifdef LFSR_ZERO_RECOVER_EN
  localparam bit ZeroRecover = 1'b1;
`else
  localparam bit ZeroRecover = 1'b0;
`endif

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] state_q, start_q, cnt_q, period_q;
  logic [WIDTH-1:0] nxt;
  logic             done_q, stuck_q;
  logic             cnt_sat, recover;

  always_comb begin
    nxt     = {^(state_q & TAPS), state_q[WIDTH-1:1]};
    cnt_sat = &cnt_q;
    recover = ZeroRecover && (state_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEED;
      start_q  <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      done_q   <= 1'b0;
      stuck_q  <= 1'b0;
    end else if (load) begin
      state_q <= seed_in;
      start_q <= seed_in;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      // A zero load leaves the flag alone; only a usable seed clears it.
      if (seed_in != '0) stuck_q <= 1'b0;
    end else if (en) begin
      if (recover) begin
        state_q <= SEED;
        start_q <= SEED;
        cnt_q   <= '0;
        done_q  <= 1'b0;
        stuck_q <= 1'b1;
      end else begin
        state_q <= nxt;
        // A saturated count means the period is unrepresentable, so never report it.
        if (nxt == start_q && !cnt_sat) begin
          done_q   <= 1'b1;
          period_q <= cnt_q + One;
          cnt_q    <= '0;
        end else begin
          done_q <= 1'b0;
          if (!cnt_sat) cnt_q <= cnt_q + One;
        end
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign out         = state_q[0];
  assign state       = state_q;
  assign period_done = done_q;
  assign period      = period_q;
  assign stuck       = stuck_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen with default parameters (x^5+x^3+1, seed 11111).
module tb_lfsr_gen;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [4:0] seed_in;
  logic       out;
  logic [4:0] state;
  logic       period_done;
  logic [4:0] period;
  logic       stuck;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-derived states after k steps from 11111.
  logic [4:0] seq [0:13] = '{5'b11111, 5'b01111, 5'b00111, 5'b10011, 5'b11001, 5'b01100,
                              5'b10110, 5'b01011, 5'b00101, 5'b10010, 5'b01001, 5'b00100,
                              5'b00010, 5'b00001};

  lfsr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .seed_in    (seed_in),
    .out        (out),
    .state      (state),
    .period_done(period_done),
    .period     (period),
    .stuck      (stuck)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_state", 32'(state), 32'h1f);
    check("rst_period", 32'(period), 0);
    check("rst_done", 32'(period_done), 0);
    check("rst_stuck", 32'(stuck), 0);
    check("rst_out", 32'(out), 1);

    // Continuous run: first states, then pulses at steps 31 and 62.
    en = 1'b1;
    for (int i = 1; i <= 62; i++) begin
      tick();
      if (i <= 5) begin
        check("seq_state", 32'(state), 32'(seq[i]));
        check("seq_out", 32'(out), 32'(seq[i][0]));
      end
      check("run_done", 32'(period_done), 32'(i == 31 || i == 62));
      if (i == 31 || i == 62) begin
        check("run_period", 32'(period), 31);
        check("run_start", 32'(state), 32'h1f);
      end
    end

    // Enable gap after step 10.
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 10; i++) tick();
    check("gap_s10", 32'(state), 32'(seq[10]));
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_hold", 32'(state), 32'(seq[10]));
      check("gap_done", 32'(period_done), 0);
    end
    en = 1'b1;
    tick();
    check("gap_s11", 32'(state), 32'(seq[11]));
    for (int i = 12; i <= 31; i++) begin
      tick();
      check("gap_done2", 32'(period_done), 32'(i == 31));
    end
    check("gap_period", 32'(period), 31);

    // Load mid-sequence at step 12.
    do_reset();
    en = 1'b1;
    for (int i = 1; i <= 12; i++) tick();
    check("ld_s12", 32'(state), 32'(seq[12]));
    en = 1'b0; load = 1'b1; seed_in = 5'b00001;
    tick();
    load = 1'b0; en = 1'b1;
    check("ld_state", 32'(state), 32'h01);
    check("ld_period_kept", 32'(period), 0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (i == 1) check("ld_step1", 32'(state), 32'h10);
      check("ld_done", 32'(period_done), 32'(i == 31));
    end
    check("ld_period", 32'(period), 31);
    check("ld_wrap", 32'(state), 32'h01);

    // Priority: load over en, rst over load.
    load = 1'b1; en = 1'b1; seed_in = 5'b10101;
    tick();
    check("pri_load_en", 32'(state), 32'h15);
    check("pri_period_kept", 32'(period), 31);
    rst = 1'b1; seed_in = 5'b00110;
    tick();
    rst = 1'b0; load = 1'b0; en = 1'b0;
    check("pri_rst_state", 32'(state), 32'h1f);
    check("pri_rst_period", 32'(period), 0);

    // Zero seed.
    load = 1'b1; seed_in = '0;
    tick();
    load = 1'b0;
    check("z_load", 32'(state), 0);
    check("z_stuck_load", 32'(stuck), 0);
    en = 1'b1;
`ifdef LFSR_ZERO_RECOVER_EN
    tick();
    check("z_recover", 32'(state), 32'h1f);
    check("z_stuck", 32'(stuck), 1);
    check("z_no_done", 32'(period_done), 0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      check("z_done", 32'(period_done), 32'(i == 31));
    end
    check("z_period", 32'(period), 31);
    check("z_sticky", 32'(stuck), 1);
    en = 1'b0; load = 1'b1; seed_in = 5'b00001;
    tick();
    load = 1'b0;
    check("z_clear", 32'(stuck), 0);
`else
    for (int i = 0; i < 3; i++) begin
      tick();
      check("z_state", 32'(state), 0);
      check("z_done", 32'(period_done), 1);
      check("z_period", 32'(period), 1);
      check("z_stuck", 32'(stuck), 0);
    end
    en = 1'b0;
    tick();
    check("z_done_off", 32'(period_done), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR, the successor to the fixed 5-bit M-sequence generator.
- Width, tap mask and reset seed are configurable.
- Adds a step enable, runtime seed load, and a parallel state output.
- Adds hardware period measurement: it detects return to the start state and reports the sequence length.
- Serves as the PRBS/M-sequence source for test-pattern and scrambler blocks.

Parameters:
- WIDTH, 5, LFSR length in bits (2..32).
- TAPS, 5'b01001, feedback mask; bit i set means state[i] is XORed into the feedback (default is x^5+x^3+1, period 31).
- SEED, 5'b11111, state loaded on reset; must be nonzero.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance the LFSR one step this cycle.
- load  input  1  load seed_in this cycle.
- seed_in  input  WIDTH  runtime seed value.
- out  output  1  serial M-sequence bit; equals state[0].
- state  output  WIDTH  current register contents.
- period_done  output  1  one-cycle pulse when a step returns state to the start value.
- period  output  WIDTH  last measured period in steps.
- stuck  output  1  zero-state flag (see Optional Feature).

Behaviour:
- Feedback: fb = XOR-reduce(state & TAPS).
- Step: state <= {fb, state[WIDTH-1:1]}.
- out is combinational from state[0]; there is no extra latency.
- Priority per edge: rst > load > en > hold.
- rst: state=SEED, start_val=SEED, step_cnt=0, period=0, period_done=0, stuck=0.
- load:
  - state=seed_in, start_val=seed_in, step_cnt=0, period_done=0.
  - period is retained.
  - en is ignored in the same cycle.
- en=1, no load or rst: compute nxt (the stepped state), then state<=nxt.
  - If nxt==start_val: period_done<=1, period<=step_cnt+1, step_cnt<=0.
  - Otherwise: period_done<=0, and step_cnt<=step_cnt+1, saturating at all-ones. Saturation means the period is not representable; period_done never fires.
- en=0: state, step_cnt and period hold; period_done<=0.
- period_done is registered. It is high in the cycle after the edge that made state==start_val and lasts exactly one cycle, even when en is held high.
- Periodicity: with en continuous, period_done recurs every `period` cycles.
- Reset or load mid-sequence: the period measurement restarts from the new start value; any partial count is discarded.
- Zero state: all-zero is a fixed point (fb=0). Without the feature below, loading 0 yields state=0 permanently. Each enabled step then has nxt==start_val, so period_done pulses every enabled cycle and period=1.

Optional Feature:
- Macro: LFSR_ZERO_RECOVER_EN.
- When defined, on any enabled step while state==0 (and no load or rst):
  - state<=SEED, start_val<=SEED, step_cnt<=0, period_done<=0.
  - stuck<=1, sticky until rst, or until a load with nonzero seed_in.
- A load of 0 sets state=0 but does not by itself set stuck.
- When not defined: stuck is tied 0, and zero-state behaviour is as described in Behaviour.

Test Plan:
- Reset then en=1 continuous (defaults) -> state sequence 11111, 01111, 00111, 10011, 11001, 01100; out=1,1,1,1,1,0; period_done pulses after the 31st step with period=31, and again 31 cycles later.
- en toggled 1-0-1 around step 10 -> state holds while en=0; period_done still occurs after exactly 31 enabled steps; period=31.
- load=1, seed_in=5'b00001 at step 12, then en continuous -> state=00001 next cycle; period_done after 31 further steps with period=31; state equals 00001 at that pulse.
- load and en together, then rst and load together -> load wins over en (state=seed_in, no step); rst wins over load (state=SEED, period=0).
- load seed_in=0, then en=1 x3, macro undefined -> state stays 0; period_done high every enabled cycle; period=1; stuck=0.
- Same stimulus with LFSR_ZERO_RECOVER_EN -> state=11111 after the first enabled step; stuck=1 and sticky; no period_done on recovery; period=31 after 31 more steps; a nonzero load clears stuck.
